mcycle_mem_responder: RTL and testbench

Memory-side responder for the multicycle MIPS core's request/response bus. The core's stage controller issues one instruction-fetch or load/store request at a time and stalls in the current state until the response arrives. This block plays the opposite role: it accepts the request, waits a fixed number of cycles, performs the word-array access, and returns a single-cycle response. It stands in for both instruction and data memory in simulation and on FPGA.

---
 rtl/mcycle_mem_responder_pkg.sv | 26 ++
 rtl/mem_word_array.sv | 31 +++
 rtl/mcycle_mem_responder.sv | 106 ++++++++++
 tb/tb_mcycle_mem_responder.sv | 267 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/mcycle_mem_responder_pkg.sv
// rtl/mcycle_mem_responder_pkg.sv - shared types and helpers for the memory responder
package mcycle_mem_responder_pkg;

   typedef logic [31:0] u32;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      WAIT = 2'd1,
      RESP = 2'd2
   } mem_state_t;

   typedef struct packed {
      logic       write;
      logic [3:0] strb;
      u32         addr;
      u32         wdata;
   } mem_req_t;

   localparam int LAT_W = 4;

   // Misaligned word access or word index beyond the array.
   function automatic logic addr_err(input u32 addr, input int depth_words);
      return (addr[1:0] != 2'b00) || ({2'b00, addr[31:2]} >= u32'(depth_words));
   endfunction

endpackage

// File: rtl/mem_word_array.sv
// rtl/mem_word_array.sv - word array with byte-strobed synchronous write and combinational read
module mem_word_array
   import mcycle_mem_responder_pkg::*;
#(
   parameter int DEPTH_WORDS = 1024,
   parameter int AW          = $clog2(DEPTH_WORDS)
) (
   input  logic          clk,
   input  logic          we,
   input  logic [AW-1:0] waddr,
   input  logic [3:0]    strb,
   input  u32            wdata,
   input  logic [AW-1:0] raddr,
   output u32            rdata
);

   u32 mem [DEPTH_WORDS];

   always_ff @(posedge clk) begin
      if (we) begin
         for (int b = 0; b < 4; b++) begin
            if (strb[b]) begin
               mem[waddr][8*b +: 8] <= wdata[8*b +: 8];
            end
         end
      end
   end

   assign rdata = mem[raddr];

endmodule

// File: rtl/mcycle_mem_responder.sv
// rtl/mcycle_mem_responder.sv - fixed-latency memory responder for the multicycle core bus
module mcycle_mem_responder
   import mcycle_mem_responder_pkg::*;
#(
   parameter int LATENCY     = 2,
   parameter int DEPTH_WORDS = 1024
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       req_valid,
   input  logic       req_write,
   input  u32         req_addr,
   input  logic [3:0] req_strb,
   input  u32         req_wdata,
   output logic       req_ready,
   output logic       resp_valid,
   output u32         resp_rdata,
   output logic       resp_err
);

   localparam int               AW     = $clog2(DEPTH_WORDS);
   localparam logic [LAT_W-1:0] LAT_M1 = LAT_W'(LATENCY - 1);

   mem_state_t       state;
   logic [LAT_W-1:0] cnt;
   mem_req_t         lat;

   u32   src_addr;
   logic src_write;
   logic src_err;
   u32   arr_rdata;
   u32   resp_rdata_d;
   logic mem_we;

   // Response data is registered on the edge entering RESP; with LATENCY==1 that
   // edge is also the accept edge, so the live request drives the lookup then.
   assign src_addr     = (state == IDLE) ? req_addr  : lat.addr;
   assign src_write    = (state == IDLE) ? req_write : lat.write;
   assign src_err      = addr_err(src_addr, DEPTH_WORDS);
   assign resp_rdata_d = (src_write || src_err) ? '0 : arr_rdata;

   assign mem_we = (state == RESP) && lat.write && !addr_err(lat.addr, DEPTH_WORDS) && !reset;

   mem_word_array #(
      .DEPTH_WORDS (DEPTH_WORDS),
      .AW          (AW)
   ) u_array (
      .clk   (clk),
      .we    (mem_we),
      .waddr (lat.addr[AW+1:2]),
      .strb  (lat.strb),
      .wdata (lat.wdata),
      .raddr (src_addr[AW+1:2]),
      .rdata (arr_rdata)
   );

   always_ff @(posedge clk) begin
      if (reset) begin
         state      <= IDLE;
         cnt        <= '0;
         req_ready  <= 1'b1;
         resp_valid <= 1'b0;
         resp_rdata <= '0;
         resp_err   <= 1'b0;
      end else begin
         resp_valid <= 1'b0;
         resp_rdata <= '0;
         resp_err   <= 1'b0;
         case (state)
            IDLE: begin
               if (req_valid) begin
                  lat       <= '{write: req_write, strb: req_strb, addr: req_addr, wdata: req_wdata};
                  cnt       <= LAT_M1;
                  req_ready <= 1'b0;
                  if (LATENCY == 1) begin
                     state      <= RESP;
                     resp_valid <= 1'b1;
                     resp_rdata <= resp_rdata_d;
                     resp_err   <= src_err;
                  end else begin
                     state <= WAIT;
                  end
               end
            end
            WAIT: begin
               cnt <= cnt - LAT_W'(1);
               if (cnt == LAT_W'(1)) begin
                  state      <= RESP;
                  resp_valid <= 1'b1;
                  resp_rdata <= resp_rdata_d;
                  resp_err   <= src_err;
               end
            end
            RESP: begin
               state     <= IDLE;
               req_ready <= 1'b1;
            end
            default: begin
               state     <= IDLE;
               req_ready <= 1'b1;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_mcycle_mem_responder.sv
// tb/tb_mcycle_mem_responder.sv - randomized self-checking bench against a word-level memory model
module tb_mcycle_mem_responder;
   import mcycle_mem_responder_pkg::*;

   localparam int DEPTH = 1024;

   logic       clk = 1'b0;
   logic       reset = 1'b1;
   logic       req_valid = 1'b0;
   logic       req_write = 1'b0;
   u32         req_addr = '0;
   logic [3:0] req_strb = '0;
   u32         req_wdata = '0;
   logic       sel = 1'b0;

   logic ready_a, valid_a, err_a, ready_b, valid_b, err_b;
   u32   rdata_a, rdata_b;
   logic req_ready, resp_valid, resp_err;
   u32   resp_rdata;

   int chk = 0;
   int pass = 0;

   u32 model [int];

   always #5 clk = ~clk;

   // sel=0 talks to the LATENCY=2 instance, sel=1 to the LATENCY=1 instance.
   mcycle_mem_responder #(.LATENCY(2), .DEPTH_WORDS(DEPTH)) dut_l2 (
      .clk(clk), .reset(reset), .req_valid(req_valid && !sel), .req_write(req_write),
      .req_addr(req_addr), .req_strb(req_strb), .req_wdata(req_wdata),
      .req_ready(ready_a), .resp_valid(valid_a), .resp_rdata(rdata_a), .resp_err(err_a));

   mcycle_mem_responder #(.LATENCY(1), .DEPTH_WORDS(DEPTH)) dut_l1 (
      .clk(clk), .reset(reset), .req_valid(req_valid && sel), .req_write(req_write),
      .req_addr(req_addr), .req_strb(req_strb), .req_wdata(req_wdata),
      .req_ready(ready_b), .resp_valid(valid_b), .resp_rdata(rdata_b), .resp_err(err_b));

   assign req_ready  = sel ? ready_b : ready_a;
   assign resp_valid = sel ? valid_b : valid_a;
   assign resp_rdata = sel ? rdata_b : rdata_a;
   assign resp_err   = sel ? err_b   : err_a;

   function automatic int lat_of(input logic s);
      return s ? 1 : 2;
   endfunction

   // Reference: memory as a map of words, one map region per instance.
   function automatic void model_txn(input logic s, input logic w, input u32 a, input logic [3:0] st,
                                     input u32 wd, output u32 exp_rd, output logic exp_e);
      int k;
      u32 old;
      exp_e  = (a % 4 != 0) || (a / 4 >= DEPTH);
      exp_rd = '0;
      if (!exp_e) begin
         k   = (s ? DEPTH : 0) + int'(a / 4);
         old = model.exists(k) ? model[k] : '0;
         if (w) begin
            for (int b = 0; b < 4; b++)
               if (st[b]) old[8*b +: 8] = wd[8*b +: 8];
            model[k] = old;
         end else begin
            exp_rd = old;
         end
      end
   endfunction

   function automatic bit known(input logic s, input u32 a);
      return model.exists((s ? DEPTH : 0) + int'(a / 4));
   endfunction

   task automatic do_txn(input logic w, input u32 a, input logic [3:0] st, input u32 wd,
                         output u32 rd, output logic e, output int lat, output logic rdy, output logic once);
      @(negedge clk);
      rdy = req_ready;
      req_write = w; req_addr = a; req_strb = st; req_wdata = wd; req_valid = 1'b1;
      @(posedge clk);
      #1 req_valid = 1'b0;
      lat = 1;
      @(negedge clk);
      while (!resp_valid && lat < 40) begin
         @(negedge clk);
         lat++;
      end
      rd = resp_rdata;
      e  = resp_err;
      @(negedge clk);
      once = !resp_valid && req_ready;
   endtask

   task automatic test_reset();
      reset = 1'b1;
      repeat (2) @(posedge clk);
      #1 reset = 1'b0;
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         chk++;
         if ({ready_a, valid_a, err_a, ready_b, valid_b, err_b} !== 6'b100100)
            $display("FAIL reset_ctrl: got %b want 100100", {ready_a, valid_a, err_a, ready_b, valid_b, err_b});
         else pass++;
         chk++;
         if ({rdata_a, rdata_b} !== 64'h0)
            $display("FAIL reset_rdata: got %h want 0", {rdata_a, rdata_b});
         else pass++;
      end
   endtask

   task automatic test_store_load();
      u32 rd, er; logic e, rdy, once; int lat;
      sel = 1'b0;
      do_txn(1'b1, 32'h10, 4'hF, 32'hDEADBEEF, rd, e, lat, rdy, once);
      model_txn(1'b0, 1'b1, 32'h10, 4'hF, 32'hDEADBEEF, er, e);
      chk++;
      if (lat !== 2 || e !== 1'b0 || rd !== 32'h0 || !rdy || !once)
         $display("FAIL store_10: got lat=%0d err=%b rdata=%h rdy=%b once=%b want 2 0 0 1 1", lat, e, rd, rdy, once);
      else pass++;
      do_txn(1'b0, 32'h10, 4'h0, 32'h0, rd, e, lat, rdy, once);
      chk++;
      if (lat !== 2 || e !== 1'b0 || rd !== 32'hDEADBEEF || !once)
         $display("FAIL load_10: got lat=%0d err=%b rdata=%h once=%b want 2 0 deadbeef 1", lat, e, rd, once);
      else pass++;
   endtask

   task automatic test_partial();
      u32 rd, er; logic e, ee, rdy, once; int lat;
      sel = 1'b0;
      do_txn(1'b1, 32'h20, 4'hF, 32'h11223344, rd, e, lat, rdy, once);
      model_txn(1'b0, 1'b1, 32'h20, 4'hF, 32'h11223344, er, ee);
      do_txn(1'b1, 32'h20, 4'b0010, 32'h0000AB00, rd, e, lat, rdy, once);
      model_txn(1'b0, 1'b1, 32'h20, 4'b0010, 32'h0000AB00, er, ee);
      do_txn(1'b0, 32'h20, 4'h0, 32'h0, rd, e, lat, rdy, once);
      chk++;
      if (rd !== 32'h1122AB44 || e !== 1'b0)
         $display("FAIL partial_store: got rdata=%h err=%b want 1122ab44 0", rd, e);
      else pass++;
   endtask

   task automatic test_errors();
      u32 rd, er; logic e, ee, rdy, once; int lat;
      sel = 1'b0;
      do_txn(1'b0, 32'h22, 4'h0, 32'h0, rd, e, lat, rdy, once);
      chk++;
      if (e !== 1'b1 || rd !== 32'h0 || lat !== 2)
         $display("FAIL misaligned_read: got err=%b rdata=%h lat=%0d want 1 0 2", e, rd, lat);
      else pass++;
      do_txn(1'b1, 32'h0, 4'hF, 32'hCAFEF00D, rd, e, lat, rdy, once);
      model_txn(1'b0, 1'b1, 32'h0, 4'hF, 32'hCAFEF00D, er, ee);
      do_txn(1'b1, u32'(DEPTH * 4), 4'hF, 32'hFFFFFFFF, rd, e, lat, rdy, once);
      chk++;
      if (e !== 1'b1 || rd !== 32'h0)
         $display("FAIL oor_store: got err=%b rdata=%h want 1 0", e, rd);
      else pass++;
      do_txn(1'b0, 32'h0, 4'h0, 32'h0, rd, e, lat, rdy, once);
      chk++;
      if (e !== 1'b0 || rd !== 32'hCAFEF00D)
         $display("FAIL word0_after_oor: got err=%b rdata=%h want 0 cafef00d", e, rd);
      else pass++;
   endtask

   task automatic test_random();
      u32 rd, er, a, wd; logic e, ee, w, s, rdy, once; logic [3:0] st; int lat, pick;
      for (int i = 0; i < 30; i++) begin
         s    = 1'(($urandom_range(0, 1)));
         sel  = s;
         pick = int'($urandom_range(0, 9));
         if (pick == 0)      a = u32'($urandom_range(DEPTH, 4 * DEPTH)) * 4;
         else if (pick == 1) a = u32'($urandom_range(0, 15)) * 4 + u32'($urandom_range(1, 3));
         else                a = 32'h100 + u32'($urandom_range(0, 15)) * 4;
         w  = 1'($urandom_range(0, 1));
         st = 4'($urandom_range(1, 15));
         wd = $urandom;
         if (!known(s, a)) st = 4'hF;
         if (!known(s, a) && pick >= 2) w = 1'b1;
         do_txn(w, a, st, wd, rd, e, lat, rdy, once);
         model_txn(s, w, a, st, wd, er, ee);
         chk++;
         if (lat !== lat_of(s) || e !== ee || rd !== er || !rdy || !once)
            $display("FAIL random_%0d: got lat=%0d err=%b rdata=%h rdy=%b once=%b want %0d %b %h 1 1",
                     i, lat, e, rd, rdy, once, lat_of(s), ee, er);
         else pass++;
      end
   endtask

   task automatic test_back_to_back(input logic s);
      logic ow [8]; u32 oa [8]; logic [3:0] os [8]; u32 od [8];
      u32 er; logic ee; int n;
      sel = s;
      for (int i = 0; i < 4; i++) begin
         ow[i] = 1'b1; oa[i] = 32'h200 + u32'(i) * 4 + u32'($urandom_range(0, 7)) * 32;
         os[i] = 4'hF; od[i] = $urandom;
         ow[i+4] = 1'b0; oa[i+4] = oa[i]; os[i+4] = 4'h0; od[i+4] = '0;
      end
      @(negedge clk);
      req_write = ow[0]; req_addr = oa[0]; req_strb = os[0]; req_wdata = od[0]; req_valid = 1'b1;
      for (int k = 0; k < 8; k++) begin
         n = 0;
         do begin
            @(negedge clk);
            n++;
         end while (!resp_valid && n < 40);
         model_txn(s, ow[k], oa[k], os[k], od[k], er, ee);
         chk++;
         if (n !== (k == 0 ? lat_of(s) : lat_of(s) + 1) || resp_rdata !== er || resp_err !== ee)
            $display("FAIL b2b_L%0d_%0d: got gap=%0d rdata=%h err=%b want %0d %h %b",
                     lat_of(s), k, n, resp_rdata, resp_err, (k == 0 ? lat_of(s) : lat_of(s) + 1), er, ee);
         else pass++;
         if (k < 7) begin
            req_write = ow[k+1]; req_addr = oa[k+1]; req_strb = os[k+1]; req_wdata = od[k+1];
         end else begin
            req_valid = 1'b0;
         end
      end
      @(negedge clk);
   endtask

   task automatic test_reset_mid();
      u32 rd, er; logic e, ee, rdy, once; int lat;
      sel = 1'b0;
      do_txn(1'b1, 32'h30, 4'hF, 32'h12345678, rd, e, lat, rdy, once);
      model_txn(1'b0, 1'b1, 32'h30, 4'hF, 32'h12345678, er, ee);
      @(negedge clk);
      req_write = 1'b1; req_addr = 32'h30; req_strb = 4'hF; req_wdata = 32'h55; req_valid = 1'b1;
      @(posedge clk);
      #1 req_valid = 1'b0;
      reset = 1'b1;
      @(posedge clk);
      #1 reset = 1'b0;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         chk++;
         if (valid_a !== 1'b0 || ready_a !== 1'b1)
            $display("FAIL reset_in_wait_%0d: got valid=%b ready=%b want 0 1", i, valid_a, ready_a);
         else pass++;
      end
      do_txn(1'b0, 32'h30, 4'h0, 32'h0, rd, e, lat, rdy, once);
      chk++;
      if (rd !== 32'h12345678 || e !== 1'b0)
         $display("FAIL aborted_store: got rdata=%h err=%b want 12345678 0", rd, e);
      else pass++;
      sel = 1'b1;
      @(negedge clk);
      req_write = 1'b0; req_addr = 32'h30; req_valid = 1'b1; reset = 1'b1;
      @(posedge clk);
      #1 req_valid = 1'b0; reset = 1'b0;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         chk++;
         if (valid_b !== 1'b0 || ready_b !== 1'b1)
            $display("FAIL reset_beats_req_%0d: got valid=%b ready=%b want 0 1", i, valid_b, ready_b);
         else pass++;
      end
   endtask

   initial begin
      test_reset();
      test_store_load();
      test_partial();
      test_errors();
      test_random();
      test_back_to_back(1'b0);
      test_back_to_back(1'b1);
      test_reset_mid();
      $display("%0d/%0d checks passed", pass, chk);
      $finish;
   end

endmodule
